// File: rtl/mul_arb_pkg.sv
// Shared constants and state encoding for the round-robin multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned DEF_N       = 4;
    localparam int unsigned DEF_W       = 8;
    localparam int unsigned DEF_TIMEOUT = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_DONE = ST_WAIT_DONE,
        RELEASE   = ST_RELEASE,
        RESP      = ST_RESP
    } state_e;

endpackage

// File: rtl/mul_arbiter_uc_rr_pick.sv
// Combinational round-robin search: first set req bit after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter_uc.sv
// Round-robin arbiter sharing one handshaked multiplier among N requesters,
// with per-edge handshake timeout reported through err.
module mul_arbiter_uc
    import mul_arb_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   op_x,
    input  logic [N*W-1:0]   op_y,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [2*W-1:0]   result,
    output logic             err,
    output logic             mul_start,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_y,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_p
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e            state, state_d;
    logic [IW-1:0]     ptr, ptr_d;
    logic [IW-1:0]     win_idx, win_idx_d;
    logic [N-1:0]      gnt_d, ack_d;
    logic              err_d, to_flag, to_flag_d, mul_start_d;
    logic [W-1:0]      mul_x_d, mul_y_d;
    logic [2*W-1:0]    result_d;
    logic [CW-1:0]     cnt, cnt_d;

    logic [N-1:0]      pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;
    logic              cnt_hit_c;
    logic [W-1:0]      xs [N];
    logic [W-1:0]      ys [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign xs[i] = op_x[i*W +: W];
        assign ys[i] = op_y[i*W +: W];
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign cnt_hit_c = (cnt == CW'(TIMEOUT - 1));

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= IW'(N - 1);
            win_idx   <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            to_flag   <= 1'b0;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            result    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            win_idx   <= win_idx_d;
            gnt       <= gnt_d;
            ack       <= ack_d;
            err       <= err_d;
            to_flag   <= to_flag_d;
            mul_start <= mul_start_d;
            mul_x     <= mul_x_d;
            mul_y     <= mul_y_d;
            result    <= result_d;
            cnt       <= cnt_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        win_idx_d   = win_idx;
        gnt_d       = gnt;
        ack_d       = '0;
        err_d       = 1'b0;
        to_flag_d   = to_flag;
        mul_start_d = mul_start;
        mul_x_d     = mul_x;
        mul_y_d     = mul_y;
        result_d    = result;
        cnt_d       = cnt + CW'(1);

        case (state)
            IDLE: begin
                gnt_d       = '0;
                to_flag_d   = 1'b0;
                mul_start_d = 1'b0;
                if (pick_vld) begin
                    win_idx_d = pick_idx;
                    gnt_d     = pick_oh;
                    mul_x_d   = xs[pick_idx];
                    mul_y_d   = ys[pick_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mul_done) begin
                    result_d    = mul_p;
                    mul_start_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RELEASE;
                end else if (cnt_hit_c) begin
                    result_d    = '0;
                    to_flag_d   = 1'b1;
                    mul_start_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // A still-high done when the count expires is the release-edge timeout
                if (!mul_done || cnt_hit_c) begin
                    ack_d   = gnt;
                    err_d   = to_flag | (mul_done & cnt_hit_c);
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = win_idx;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_arbiter_uc.sv
// Directed-plus-random bench for mul_arbiter_uc with a behavioural multiplier
// responder and a round-robin reference model.
module tb_mul_arbiter_uc;

    localparam int unsigned N       = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned PW      = 2 * W;
    localparam int unsigned XW      = N * W;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [XW-1:0]   op_x, op_y;
    logic [N-1:0]    gnt, ack;
    logic [PW-1:0]   result;
    logic            err;
    logic            mul_start;
    logic [W-1:0]    mul_x, mul_y;
    logic            mul_done;
    logic [PW-1:0]   mul_p;

    mul_arbiter_uc #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_x      (op_x),
        .op_y      (op_y),
        .gnt       (gnt),
        .ack       (ack),
        .result    (result),
        .err       (err),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_done  (mul_done),
        .mul_p     (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int m_lat   = 7;
    int m_rel   = 1;
    int m_cnt   = 0;
    bit m_stuck = 1'b0;
    bit m_hold  = 1'b0;

    int            rr_last = N - 1;
    logic [W-1:0]  xs [N];
    logic [W-1:0]  ys [N];

    // Multiplier responder: done rises m_lat cycles after start, falls m_rel after start drops
    always @(negedge clk) begin
        if (!rst) begin
            mul_done = 1'b0;
            m_cnt    = 0;
        end else if (mul_start && !mul_done) begin
            if (!m_stuck) begin
                m_cnt++;
                if (m_cnt >= m_lat) begin
                    mul_done = 1'b1;
                    mul_p    = PW'(mul_x) * PW'(mul_y);
                    m_cnt    = 0;
                end
            end
        end else if (!mul_start && mul_done) begin
            if (!m_hold) begin
                m_cnt++;
                if (m_cnt >= m_rel) begin
                    mul_done = 1'b0;
                    m_cnt    = 0;
                end
            end
        end else begin
            m_cnt = 0;
        end
        if (!mul_done) mul_p = PW'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_expect(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((r >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnt"},       64'(gnt),       64'(0));
        check({tag, " ack"},       64'(ack),       64'(0));
        check({tag, " err"},       64'(err),       64'(0));
        check({tag, " mul_start"}, 64'(mul_start), 64'(0));
        check({tag, " mul_x"},     64'(mul_x),     64'(0));
        check({tag, " mul_y"},     64'(mul_y),     64'(0));
        check({tag, " result"},    64'(result),    64'(0));
    endtask

    // One arbitrated transaction; returns on the negedge after the ack cycle
    task automatic run_txn(input string tag, input logic [N-1:0] rq, input bit drop,
                           input bit exp_err, input bit exp_zero);
        int            exp_idx;
        logic [N-1:0]  exp_oh;
        logic [PW-1:0] exp_res;
        bit            got;
        bit            ops_ok;
        for (int i = 0; i < N; i++) begin
            op_x[i*W +: W] = xs[i];
            op_y[i*W +: W] = ys[i];
        end
        req     = rq;
        exp_idx = rr_expect(rq, rr_last);
        exp_oh  = N'(1) << exp_idx;
        exp_res = exp_zero ? PW'(0) : PW'(xs[exp_idx]) * PW'(ys[exp_idx]);

        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        check({tag, " grant"}, 64'(gnt), 64'(exp_oh));
        if (!got) return;

        if (drop) req = '0;
        op_x = XW'($urandom);
        op_y = XW'($urandom);

        ops_ok = 1'b1;
        got    = 1'b0;
        for (int c = 0; c < 3 * TIMEOUT + 20 && !got; c++) begin
            if (mul_x !== xs[exp_idx] || mul_y !== ys[exp_idx] || gnt !== exp_oh) ops_ok = 1'b0;
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        check({tag, " ack"},        64'(ack),       64'(exp_oh));
        check({tag, " err"},        64'(err),       64'(exp_err));
        check({tag, " result"},     64'(result),    64'(exp_res));
        check({tag, " start_low"},  64'(mul_start), 64'(0));
        check({tag, " ops_stable"}, 64'(ops_ok),    64'(1));
        rr_last = exp_idx;

        @(negedge clk);
        check({tag, " after_ack"},  64'({ack, err, gnt}), 64'(0));
    endtask

    initial begin
        logic [N-1:0] rq;
        bit           got;

        rst  = 1'b0;
        req  = '0;
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single request, 13*11
        xs[0] = 8'd13; ys[0] = 8'd11; m_lat = 7;
        run_txn("single", 4'b0001, 1'b0, 1'b0, 1'b0);
        req = '0;
        check("single const", 64'(result), 64'(143));

        // Contention from a fresh reset: 0,1,2,3
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rr_last = N - 1;
        m_lat = 2;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = W'($urandom);
                ys[i] = W'($urandom);
            end
            run_txn("contend", 4'b1111, 1'b0, 1'b0, 1'b0);
            check("contend order", 64'(rr_last), 64'(t));
        end

        // Fairness: 0,2,0,2 with req held across ack
        for (int t = 0; t < 4; t++) begin
            xs[0] = W'($urandom); ys[0] = W'($urandom);
            xs[2] = W'($urandom); ys[2] = W'($urandom);
            run_txn("fair", 4'b0101, 1'b0, 1'b0, 1'b0);
            check("fair order", 64'(rr_last), 64'((t % 2) * 2));
        end
        req = '0;

        // Done never rises: timeout in WAIT_DONE
        m_stuck = 1'b1;
        xs[1] = 8'd200; ys[1] = 8'd3;
        run_txn("timeout_wait", 4'b0010, 1'b0, 1'b1, 1'b1);
        req = '0;
        m_stuck = 1'b0;

        // Done never falls: timeout in RELEASE keeps the product
        m_hold = 1'b1;
        xs[3] = 8'd17; ys[3] = 8'd9;
        run_txn("timeout_rel", 4'b1000, 1'b0, 1'b1, 1'b0);
        req = '0;
        m_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Operand stability: 255*255 while op_x is scrambled, req dropped early
        xs[2] = 8'd255; ys[2] = 8'd255;
        run_txn("opstab", 4'b0100, 1'b1, 1'b0, 1'b0);
        req = '0;
        check("opstab const", 64'(result), 64'(65025));

        // Reset while waiting on the multiplier
        m_stuck = 1'b1;
        xs[1] = W'($urandom); ys[1] = W'($urandom);
        op_x[W +: W] = xs[1];
        op_y[W +: W] = ys[1];
        req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (mul_start) got = 1'b1;
        end
        check("midrst reached_wait", 64'(mul_start), 64'(1));
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst async");
        req = '0;
        got = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        check("midrst no_ack", 64'(got), 64'(0));
        m_stuck = 1'b0;
        rst = 1'b1;
        rr_last = N - 1;
        m_lat = 4;
        run_txn("after_rst", 4'b0010, 1'b0, 1'b0, 1'b0);
        req = '0;

        // Random traffic
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = W'($urandom);
                ys[i] = W'($urandom);
            end
            m_lat = int'($urandom_range(1, 6));
            m_rel = int'($urandom_range(1, 3));
            rq = N'($urandom_range(1, (1 << N) - 1));
            run_txn("random", rq, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
